// File: rtl/blink_seq_if.sv
// Handshake bundle between a blink_seq pattern sequencer and its controller.
// The controller drives the time base, start request and pattern; the sequencer returns led/busy/done.
interface blink_seq_if #(
   parameter int PLEN  = 8,
   parameter int RBITS = 4
);
   logic             tick;
   logic             start;
   logic [PLEN-1:0]  pattern;
   logic [RBITS-1:0] repeats;
   logic             led;
   logic             busy;
   logic             done;

   modport master (
      output tick, start, pattern, repeats,
      input  led, busy, done
   );

   modport slave (
      input  tick, start, pattern, repeats,
      output led, busy, done
   );
endinterface

// File: rtl/blink_seq.sv
// LED pattern sequencer clocked by the blink counter's wrap tick: plays a latched pattern repeats+1 times.
// Define BLINK_SEQ_GAP_EN to add a dark gap of GAP_TICKS ticks before the done pulse.
module blink_seq #(
   parameter int PLEN  = 8,
   parameter int RBITS = 4
`ifdef BLINK_SEQ_GAP_EN
   ,
   parameter int GAP_TICKS = 4
`endif
) (
   input  logic     clk,
   input  logic     rst,
   blink_seq_if.slave bus
);

   localparam int IW = (PLEN > 1) ? $clog2(PLEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PLEN - 1);

`ifdef BLINK_SEQ_GAP_EN
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_TICKS - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
`ifdef BLINK_SEQ_GAP_EN
      S_GAP  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             led_q,   led_d;
   logic [IW-1:0]    idx_q,   idx_d;
   logic [RBITS-1:0] rep_q,   rep_d;
   logic [PLEN-1:0]  pat_q,   pat_d;
`ifdef BLINK_SEQ_GAP_EN
   logic [GW-1:0]    gap_q,   gap_d;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         led_q   <= 1'b0;
         idx_q   <= '0;
         rep_q   <= '0;
         pat_q   <= '0;
`ifdef BLINK_SEQ_GAP_EN
         gap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         pat_q   <= pat_d;
`ifdef BLINK_SEQ_GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

   // NOTE: every variable gets a hold default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      pat_d   = pat_q;
`ifdef BLINK_SEQ_GAP_EN
      gap_d   = gap_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            led_d = 1'b0;
            if (bus.start) begin
               pat_d   = bus.pattern;
               rep_d   = bus.repeats;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (bus.tick) begin
               led_d = pat_q[idx_q];
               if (idx_q != LAST_IDX) begin
                  idx_d = idx_q + IW'(1);
               end else if (rep_q != '0) begin
                  idx_d = '0;
                  rep_d = rep_q - RBITS'(1);
               end else begin
                  // Final bit of the final pass; it stays on led until the next transition.
`ifdef BLINK_SEQ_GAP_EN
                  gap_d   = '0;
                  state_d = S_GAP;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end

`ifdef BLINK_SEQ_GAP_EN
         S_GAP: begin
            if (bus.tick) begin
               led_d = 1'b0;
               if (gap_q == LAST_GAP) begin
                  gap_d   = '0;
                  state_d = S_DONE;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end
`endif

         S_DONE: begin
            led_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.led  = led_q;
`ifdef BLINK_SEQ_GAP_EN
   assign bus.busy = (state_q == S_RUN) || (state_q == S_GAP);
`else
   assign bus.busy = (state_q == S_RUN);
`endif
   assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_blink_seq.sv
// Self-checking bench for blink_seq: directed scenarios plus randomized runs against a tick-level model.
// The model expands each sequence into its list of per-tick led values and tracks ticks consumed.
module tb_blink_seq;

   localparam int PLEN  = 8;
   localparam int RBITS = 4;
`ifdef BLINK_SEQ_GAP_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   blink_seq_if #(.PLEN(PLEN), .RBITS(RBITS)) bus ();

   blink_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic el, input logic eb, input logic ed);
      check({tag, ".led"},  32'(bus.led),  32'(el));
      check({tag, ".busy"}, 32'(bus.busy), 32'(eb));
      check({tag, ".done"}, 32'(bus.done), 32'(ed));
   endtask

   function automatic logic tick_for(input int period, input int cyc);
      if (period == 0) return 1'($urandom_range(0, 1));
      return (cyc % period) == 0;
   endfunction

   // One full sequence: accept start, then check every cycle against the expanded led list.
   task automatic run_seq(input logic [PLEN-1:0] pat, input logic [RBITS-1:0] reps,
                          input int period, input bit tick_at_start, input bit poke_start);
      logic exp_seq[$];
      int   len;
      int   k;
      int   cyc;
      logic exp_led;

      for (int i = 0; i < PLEN * (int'(reps) + 1); i++) exp_seq.push_back(pat[i % PLEN]);
      for (int i = 0; i < GAP; i++) exp_seq.push_back(1'b0);
      len = exp_seq.size();

      bus.start   = 1'b1;
      bus.pattern = pat;
      bus.repeats = reps;
      bus.tick    = tick_at_start;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.pattern = PLEN'($urandom);
      bus.repeats = RBITS'($urandom);
      check_outs("accept", 1'b0, 1'b1, 1'b0);

      k   = 0;
      cyc = 1;
      while (k < len && cyc < 4000) begin
         bus.tick = tick_for(period, cyc);
         if (poke_start && cyc == 5) begin
            bus.start   = 1'b1;
            bus.pattern = ~pat;
            bus.repeats = '0;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.tick) k++;
         cyc++;
         if (k < len) begin
            exp_led = (k == 0) ? 1'b0 : exp_seq[k-1];
            check_outs("run", exp_led, 1'b1, 1'b0);
         end
      end
      bus.start = 1'b0;

      check("tick_budget", 32'(k), 32'(len));
      if (k == len) begin
         check_outs("done", exp_seq[len-1], 1'b0, 1'b1);
         bus.tick = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         check_outs("idle_after", 1'b0, 1'b0, 1'b0);
      end
      bus.tick = 1'b0;
   endtask

   initial begin
      bus.tick    = 1'b0;
      bus.start   = 1'b0;
      bus.pattern = '0;
      bus.repeats = '0;

      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0);
      rst = 1'b1;

      // Ticks in IDLE without start are ignored.
      for (int i = 0; i < 4; i++) begin
         bus.tick = 1'b1;
         @(posedge clk); #1;
         check_outs("idle_tick", 1'b0, 1'b0, 1'b0);
      end
      bus.tick = 1'b0;

      run_seq(8'b1010_0011, 4'd0, 4, 1'b0, 1'b0);
      run_seq(8'hF0,        4'd2, 1, 1'b0, 1'b0);
      run_seq(8'h5A,        4'd1, 3, 1'b0, 1'b1);
      run_seq(8'b0110_1001, 4'd0, 2, 1'b1, 1'b0);

      // Asynchronous reset mid-run, between clock edges.
      bus.start   = 1'b1;
      bus.pattern = 8'hFF;
      bus.repeats = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.tick  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outs("pre_reset", 1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_outs("async_reset", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outs("in_reset", 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_outs("post_reset", 1'b0, 1'b0, 1'b0);
      end
      bus.tick = 1'b0;
      run_seq(8'b1000_0001, 4'd0, 1, 1'b0, 1'b0);

      run_seq(8'h00, 4'd1, 0, 1'b0, 1'b0);
      run_seq(PLEN'($urandom), 4'hF, 1, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         run_seq(PLEN'($urandom), RBITS'($urandom_range(0, 3)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
